// File: rtl/q_episode_driver.sv
// Gridworld agent driving the q_learning_core start/done interface: chooses an action,
// computes s' and a Q4.12 reward, issues one start per transition and tracks episodes.
module q_episode_driver #(
    parameter int unsigned        GRID_ROWS = 10,
    parameter int unsigned        GRID_COLS = 10,
    parameter int unsigned        START_ROW = 0,
    parameter int unsigned        START_COL = 0,
    parameter int unsigned        GOAL_ROW  = 9,
    parameter int unsigned        GOAL_COL  = 9,
    parameter int unsigned        MAX_STEPS = 255,
    parameter logic signed [15:0] R_STEP    = -16'sd4096,
    parameter logic signed [15:0] R_WALL    = -16'sd20480,
    parameter logic signed [15:0] R_GOAL    = 16'sd28672,
    parameter logic [15:0]        LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               act_force_en,
    input  logic [1:0]         act_force,
    input  logic               core_done,
    output logic               start,
    output logic [4:0]         s_row,
    output logic [4:0]         s_col,
    output logic [4:0]         s_prime_row,
    output logic [4:0]         s_prime_col,
    output logic [1:0]         action,
    output logic signed [15:0] reward,
    output logic               busy,
    output logic               episode_done,
    output logic [7:0]         step_cnt,
    output logic [15:0]        episode_cnt
);

    localparam int unsigned POS_W = 5;
    localparam int unsigned EXT_W = 6;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned EP_W  = 16;
    localparam int unsigned LF_W  = 16;

    localparam logic [LF_W-1:0]  LFSR_MASK = 16'hB400;
    localparam logic [LF_W-1:0]  SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [POS_W-1:0] START_R   = POS_W'(START_ROW);
    localparam logic [POS_W-1:0] START_C   = POS_W'(START_COL);
    localparam logic [POS_W-1:0] GOAL_R    = POS_W'(GOAL_ROW);
    localparam logic [POS_W-1:0] GOAL_C    = POS_W'(GOAL_COL);
    localparam logic [EXT_W-1:0] ROWS_X    = EXT_W'(GRID_ROWS);
    localparam logic [EXT_W-1:0] COLS_X    = EXT_W'(GRID_COLS);
    localparam logic [CNT_W-1:0] STEP_LIM  = CNT_W'(MAX_STEPS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHOOSE,
        S_COMPUTE,
        S_ISSUE,
        S_WAIT,
        S_ADVANCE
    } state_t;

    state_t             state, state_nxt;
    logic [LF_W-1:0]    lfsr, lfsr_nxt, lfsr_step;
    logic               armed, armed_nxt;
    logic [POS_W-1:0]   s_row_nxt, s_col_nxt, sp_row_nxt, sp_col_nxt;
    logic [1:0]         action_nxt;
    logic signed [15:0] reward_nxt;
    logic               start_nxt, busy_nxt, episode_done_nxt;
    logic [CNT_W-1:0]   step_cnt_nxt, step_inc;
    logic [EP_W-1:0]    episode_cnt_nxt;
    logic [EXT_W-1:0]   tgt_row, tgt_col;
    logic               off_grid, tgt_goal, ep_end;

    // Candidate move from the current state and registered action
    always_comb begin
        tgt_row  = {1'b0, s_row};
        tgt_col  = {1'b0, s_col};
        off_grid = 1'b0;
        case (action)
            2'd0: begin
                tgt_row  = {1'b0, s_row} - EXT_W'(1);
                off_grid = (s_row == '0);
            end
            2'd1: begin
                tgt_row  = {1'b0, s_row} + EXT_W'(1);
                off_grid = (tgt_row >= ROWS_X);
            end
            2'd2: begin
                tgt_col  = {1'b0, s_col} - EXT_W'(1);
                off_grid = (s_col == '0);
            end
            default: begin
                tgt_col  = {1'b0, s_col} + EXT_W'(1);
                off_grid = (tgt_col >= COLS_X);
            end
        endcase
        tgt_goal = (tgt_row[POS_W-1:0] == GOAL_R) && (tgt_col[POS_W-1:0] == GOAL_C);
    end

    assign lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
    assign step_inc  = step_cnt + CNT_W'(1);
    assign ep_end    = ((s_prime_row == GOAL_R) && (s_prime_col == GOAL_C)) || (step_inc == STEP_LIM);

    // Next-state and next-output logic
    always_comb begin
        state_nxt        = state;
        lfsr_nxt         = lfsr;
        armed_nxt        = armed;
        s_row_nxt        = s_row;
        s_col_nxt        = s_col;
        sp_row_nxt       = s_prime_row;
        sp_col_nxt       = s_prime_col;
        action_nxt       = action;
        reward_nxt       = reward;
        start_nxt        = 1'b0;
        episode_done_nxt = 1'b0;
        step_cnt_nxt     = step_cnt;
        episode_cnt_nxt  = episode_cnt;

        case (state)
            S_IDLE: begin
                if (run) state_nxt = S_CHOOSE;
            end
            S_CHOOSE: begin
                lfsr_nxt   = lfsr_step;
                action_nxt = act_force_en ? act_force : lfsr_step[1:0];
                state_nxt  = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (off_grid) begin
                    sp_row_nxt = s_row;
                    sp_col_nxt = s_col;
                    reward_nxt = R_WALL;
                end else begin
                    sp_row_nxt = tgt_row[POS_W-1:0];
                    sp_col_nxt = tgt_col[POS_W-1:0];
                    reward_nxt = tgt_goal ? R_GOAL : R_STEP;
                end
                start_nxt = 1'b1;
                armed_nxt = 1'b0;
                state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (!core_done) armed_nxt = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A done that was already high when the request went out never completes it
                if (core_done && armed) begin
                    state_nxt = S_ADVANCE;
                    if (ep_end) begin
                        s_row_nxt        = START_R;
                        s_col_nxt        = START_C;
                        step_cnt_nxt     = '0;
                        episode_cnt_nxt  = episode_cnt + EP_W'(1);
                        episode_done_nxt = 1'b1;
                    end else begin
                        s_row_nxt    = s_prime_row;
                        s_col_nxt    = s_prime_col;
                        step_cnt_nxt = step_inc;
                    end
                end else if (!core_done) begin
                    armed_nxt = 1'b1;
                end
            end
            S_ADVANCE: begin
                state_nxt = run ? S_CHOOSE : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            lfsr         <= SEED_EFF;
            armed        <= 1'b0;
            s_row        <= START_R;
            s_col        <= START_C;
            s_prime_row  <= '0;
            s_prime_col  <= '0;
            action       <= '0;
            reward       <= '0;
            start        <= 1'b0;
            busy         <= 1'b0;
            episode_done <= 1'b0;
            step_cnt     <= '0;
            episode_cnt  <= '0;
        end else begin
            state        <= state_nxt;
            lfsr         <= lfsr_nxt;
            armed        <= armed_nxt;
            s_row        <= s_row_nxt;
            s_col        <= s_col_nxt;
            s_prime_row  <= sp_row_nxt;
            s_prime_col  <= sp_col_nxt;
            action       <= action_nxt;
            reward       <= reward_nxt;
            start        <= start_nxt;
            busy         <= busy_nxt;
            episode_done <= episode_done_nxt;
            step_cnt     <= step_cnt_nxt;
            episode_cnt  <= episode_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_q_episode_driver.sv
// Scoreboard bench for q_episode_driver: a gridworld reference model predicts every transaction,
// a monitor checks each start pulse, and the stimulus side checks post-transition state.
module tb_q_episode_driver;

    localparam int ROWS = 4;
    localparam int COLS = 5;
    localparam int GR   = 1;
    localparam int GC   = 2;
    localparam int MAXS = 5;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               run;
    logic               act_force_en;
    logic [1:0]         act_force;
    logic               core_done;
    logic               start;
    logic [4:0]         s_row, s_col, s_prime_row, s_prime_col;
    logic [1:0]         action;
    logic signed [15:0] reward;
    logic               busy, episode_done;
    logic [7:0]         step_cnt;
    logic [15:0]        episode_cnt;

    q_episode_driver #(
        .GRID_ROWS(ROWS), .GRID_COLS(COLS), .START_ROW(0), .START_COL(0),
        .GOAL_ROW(GR), .GOAL_COL(GC), .MAX_STEPS(MAXS),
        .R_STEP(-16'sd4096), .R_WALL(-16'sd20480), .R_GOAL(16'sd28672),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .act_force_en(act_force_en),
        .act_force(act_force), .core_done(core_done), .start(start),
        .s_row(s_row), .s_col(s_col), .s_prime_row(s_prime_row), .s_prime_col(s_prime_col),
        .action(action), .reward(reward), .busy(busy), .episode_done(episode_done),
        .step_cnt(step_cnt), .episode_cnt(episode_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int sr;
        int sc;
        int pr;
        int pc;
        int rw;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;

    int          m_row, m_col, m_step, m_ep, m_pr, m_pc, m_rw;
    logic [15:0] m_lfsr;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic finish_now(input string why);
        checks++;
        errors++;
        $display("FAIL %s t=%0t", why, $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic model_reset();
        m_row  = 0;
        m_col  = 0;
        m_step = 0;
        m_ep   = 0;
        m_lfsr = 16'hACE1;
    endtask

    // Predict the next transaction from gridworld rules and queue it
    task automatic predict(input logic fe, input logic [1:0] fa);
        exp_t e;
        int   tr, tc;
        m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        e.a  = fe ? int'(fa) : int'(m_lfsr[1:0]);
        tr = m_row;
        tc = m_col;
        if (e.a == 0) tr = tr - 1;
        else if (e.a == 1) tr = tr + 1;
        else if (e.a == 2) tc = tc - 1;
        else tc = tc + 1;
        if (tr < 0 || tr >= ROWS || tc < 0 || tc >= COLS) begin
            m_pr = m_row;
            m_pc = m_col;
            m_rw = -20480;
        end else begin
            m_pr = tr;
            m_pc = tc;
            m_rw = (tr == GR && tc == GC) ? 28672 : -4096;
        end
        e.sr = m_row;
        e.sc = m_col;
        e.pr = m_pr;
        e.pc = m_pc;
        e.rw = m_rw;
        sb_q.push_back(e);
    endtask

    task automatic wait_start();
        int n = 0;
        while (start !== 1'b1) begin
            @(posedge clk); #1;
            n++;
            if (n > 60) finish_now("start_timeout");
        end
    endtask

    // One transition: predict, wait for start, answer with done after d cycles, check result
    task automatic do_step(input logic fe, input logic [1:0] fa, input int d,
                           input bit keep_run, input bit stale);
        int exp_ed;
        act_force_en = fe;
        act_force    = fa;
        run          = 1'b1;
        predict(fe, fa);
        if (stale) core_done = 1'b1;
        wait_start();
        repeat (d) begin
            @(posedge clk); #1;
        end
        if (stale) begin
            check("stale_busy", int'(busy), 1);
            check("stale_step_cnt", int'(step_cnt), m_step);
            check("stale_s_row", int'(s_row), m_row);
            check("stale_sp_col", int'(s_prime_col), m_pc);
            check("stale_reward", int'($signed(reward)), m_rw);
            core_done = 1'b0;
            @(posedge clk); #1;
        end
        if (!keep_run) run = 1'b0;
        core_done = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b0;
        m_step++;
        if ((m_pr == GR && m_pc == GC) || m_step == MAXS) begin
            m_row  = 0;
            m_col  = 0;
            m_step = 0;
            m_ep   = (m_ep + 1) % 65536;
            exp_ed = 1;
        end else begin
            m_row  = m_pr;
            m_col  = m_pc;
            exp_ed = 0;
        end
        check("episode_done", int'(episode_done), exp_ed);
        check("s_row", int'(s_row), m_row);
        check("s_col", int'(s_col), m_col);
        check("step_cnt", int'(step_cnt), m_step);
        check("episode_cnt", int'(episode_cnt), m_ep);
        check("busy_adv", int'(busy), 1);
        if (!keep_run) begin
            @(posedge clk); #1;
            check("busy_idle", int'(busy), 0);
            check("ep_done_low", int'(episode_done), 0);
        end
    endtask

    // Monitor: every start pulse must match the oldest predicted transaction
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && start === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_start actual=1 expected=0 t=%0t", $time);
            end else begin
                e = sb_q.pop_front();
                check("mon_action", int'(action), e.a);
                check("mon_s_row", int'(s_row), e.sr);
                check("mon_s_col", int'(s_col), e.sc);
                check("mon_sp_row", int'(s_prime_row), e.pr);
                check("mon_sp_col", int'(s_prime_col), e.pc);
                check("mon_reward", int'($signed(reward)), e.rw);
            end
        end
    end

    initial begin
        #400000;
        finish_now("watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        run          = 1'b0;
        act_force_en = 1'b0;
        act_force    = 2'd0;
        core_done    = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_start", int'(start), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_s_row", int'(s_row), 0);
        check("rst_sp_row", int'(s_prime_row), 0);
        check("rst_reward", int'($signed(reward)), 0);
        check("rst_step_cnt", int'(step_cnt), 0);
        check("rst_episode_cnt", int'(episode_cnt), 0);
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("idle_busy", int'(busy), 0);

        // Directed walk: wall, down, right, right into goal
        do_step(1'b1, 2'd0, 3, 1'b1, 1'b0);
        do_step(1'b1, 2'd1, 5, 1'b1, 1'b0);
        do_step(1'b1, 2'd3, 1, 1'b1, 1'b0);
        do_step(1'b1, 2'd3, 2, 1'b1, 1'b0);
        // Step limit by walls, stopping after the episode end
        for (int i = 0; i < MAXS; i++) do_step(1'b1, 2'd0, 1 + i, 1'b1, 1'b0);
        do_step(1'b1, 2'd2, 2, 1'b0, 1'b0);
        repeat (5) begin
            @(posedge clk); #1;
        end
        // Goal reached on the step that also hits the limit (from (0,0) after one wall above)
        do_step(1'b1, 2'd3, 2, 1'b1, 1'b0);
        do_step(1'b1, 2'd3, 1, 1'b1, 1'b0);
        do_step(1'b1, 2'd0, 1, 1'b1, 1'b0);
        do_step(1'b1, 2'd1, 3, 1'b1, 1'b0);
        // Held-high done must stall the transaction
        do_step(1'b1, 2'd1, 30, 1'b1, 1'b1);
        do_step(1'b1, 2'd2, 50, 1'b1, 1'b0);

        // Randomized run with pauses
        for (int i = 0; i < 60; i++) begin
            do_step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    int'($urandom_range(1, 6)), ($urandom_range(0, 4) != 0),
                    ($urandom_range(0, 9) == 0));
            if (run == 1'b0) begin
                repeat (int'($urandom_range(0, 4))) begin
                    @(posedge clk); #1;
                end
            end
        end

        // Reset while waiting for done
        act_force_en = 1'b1;
        act_force    = 2'd1;
        run          = 1'b1;
        predict(1'b1, 2'd1);
        wait_start();
        @(posedge clk); #3;
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        check("wrst_start", int'(start), 0);
        check("wrst_busy", int'(busy), 0);
        check("wrst_s_col", int'(s_col), 0);
        check("wrst_step_cnt", int'(step_cnt), 0);
        check("wrst_episode_cnt", int'(episode_cnt), 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("wrst_idle_busy", int'(busy), 0);
        for (int i = 0; i < 8; i++)
            do_step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    int'($urandom_range(1, 4)), 1'b1, 1'b0);
        do_step(1'b1, 2'd0, 2, 1'b0, 1'b0);

        repeat (4) begin
            @(posedge clk); #1;
        end
        check("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
